// File: rtl/prco_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised line, mid-bit sampling, byte strobe and framing-error pulse.
// Sits between the board RX pin and the core's receive handling.
module prco_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] q_rx_byte,
    output logic       q_rx_valid,
    output logic       q_frame_err,
    output logic       q_busy
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [7:0]       byte_nxt;
    logic             valid_nxt;
    logic             err_nxt;
    logic             rx_meta;
    logic             rx_s;

    // Synchroniser presets to idle-high so reset never fakes a start edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            q_rx_byte   <= '0;
            q_rx_valid  <= 1'b0;
            q_frame_err <= 1'b0;
            q_busy      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            shreg       <= shreg_nxt;
            q_rx_byte   <= byte_nxt;
            q_rx_valid  <= valid_nxt;
            q_frame_err <= err_nxt;
            q_busy      <= (state_nxt != S_IDLE);
        end
    end

    // Next-state: counter restarts from zero on every state change.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = idx;
        shreg_nxt = shreg;
        byte_nxt  = q_rx_byte;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (cnt == HALF_CNT) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt = S_DATA;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt == FULL_CNT) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {rx_s, shreg[7:1]};
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt == FULL_CNT) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        byte_nxt  = shreg;
                        valid_nxt = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prco_uart_rx.sv
// Bench for prco_uart_rx at 16 clocks per bit: directed frames plus random bytes,
// compared against a queue of the bytes the line carried.
module tb_prco_uart_rx;

    localparam int unsigned CPB = 16;

    logic       i_clk;
    logic       i_reset;
    logic       i_rx;
    logic [7:0] q_rx_byte;
    logic       q_rx_valid;
    logic       q_frame_err;
    logic       q_busy;

    int checks;
    int errors;

    int cyc;
    int t_fall;
    int last_valid_cyc;
    int err_seen;
    int overlap;
    logic prev_valid;
    logic prev_err;
    logic [7:0] rx_q[$];

    logic [7:0] exp_q[$];
    logic [7:0] exp_byte;
    int exp_err;

    prco_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W(16)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_rx(i_rx),
        .q_rx_byte(q_rx_byte),
        .q_rx_valid(q_rx_valid),
        .q_frame_err(q_frame_err),
        .q_busy(q_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Output monitor: collects received bytes, counts error pulses, flags pulse abuse.
    always @(negedge i_clk) begin
        if (q_rx_valid) begin
            rx_q.push_back(q_rx_byte);
            last_valid_cyc = cyc;
        end
        if (q_frame_err) err_seen++;
        if (q_rx_valid && q_frame_err) overlap++;
        if ((q_rx_valid && prev_valid) || (q_frame_err && prev_err)) overlap++;
        prev_valid = q_rx_valid;
        prev_err   = q_frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int clks, input logic stop);
        @(negedge i_clk);
        i_rx   = 1'b0;
        t_fall = cyc;
        repeat (clks) @(negedge i_clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (clks) @(negedge i_clk);
        end
        i_rx = stop;
        repeat (clks) @(negedge i_clk);
        i_rx = 1'b1;
    endtask

    // Reference: a well-framed byte is expected verbatim; a bad stop bit keeps the old byte.
    task automatic send_good(input logic [7:0] b, input int clks);
        send_frame(b, clks, 1'b1);
        exp_q.push_back(b);
        exp_byte = b;
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
        check({tag, "_errs"}, 32'(err_seen), 32'(exp_err));
        check({tag, "_hold"}, 32'(q_rx_byte), 32'(exp_byte));
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; t_fall = 0; last_valid_cyc = 0;
        err_seen = 0; overlap = 0; prev_valid = 1'b0; prev_err = 1'b0;
        exp_byte = 8'h00; exp_err = 0;
        i_rx = 1'b1;
        i_reset = 1'b1;
        idle(3);
        i_reset = 1'b0;
        check("reset_byte",  32'(q_rx_byte),   32'h00);
        check("reset_valid", 32'(q_rx_valid),  32'h0);
        check("reset_err",   32'(q_frame_err), 32'h0);
        check("reset_busy",  32'(q_busy),      32'h0);
        idle(5);

        // Single frame plus latency from the start-bit falling edge.
        send_good(8'hA5, CPB);
        idle(2 * CPB);
        check("latency_ok", 32'((last_valid_cyc - t_fall) >= (CPB/2 + 9*CPB + 1) &&
                                (last_valid_cyc - t_fall) <= (CPB/2 + 9*CPB + 3)), 32'h1);
        compare_rx("a5");

        // Back-to-back frames, one stop bit each.
        send_good(8'h00, CPB);
        send_good(8'hFF, CPB);
        send_good(8'h55, CPB);
        idle(2 * CPB);
        compare_rx("b2b");

        // Short low glitch is rejected without pulses.
        @(negedge i_clk);
        i_rx = 1'b0;
        idle(4);
        check("glitch_busy", 32'(q_busy), 32'h1);
        i_rx = 1'b1;
        idle(2 * CPB);
        check("glitch_idle", 32'(q_busy), 32'h0);
        compare_rx("glitch");

        // Bad stop bit followed by a long break: a single error, byte held.
        send_frame(8'h3C, CPB, 1'b0);
        i_rx = 1'b0;
        idle(40 * CPB);
        i_rx = 1'b1;
        exp_err++;
        idle(2 * CPB);
        check("break_busy", 32'(q_busy), 32'h0);
        compare_rx("break");
        send_good(8'h81, CPB);
        idle(2 * CPB);
        compare_rx("after_break");

        // Reset in the middle of the data bits of 0x77 aborts silently.
        @(negedge i_clk);
        i_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            i_rx = 1'(8'h77 >> i);
            idle(CPB);
        end
        i_reset = 1'b1;
        i_rx = 1'b1;
        idle(1);
        check("midreset_byte",  32'(q_rx_byte),   32'h00);
        check("midreset_valid", 32'(q_rx_valid),  32'h0);
        check("midreset_err",   32'(q_frame_err), 32'h0);
        check("midreset_busy",  32'(q_busy),      32'h0);
        i_reset = 1'b0;
        exp_byte = 8'h00;
        idle(12 * CPB);
        compare_rx("aborted");
        send_good(8'h12, CPB);
        idle(2 * CPB);
        compare_rx("after_reset");

        // Bit-rate skew on both sides.
        send_good(8'hC3, CPB - 1);
        idle(2 * CPB);
        compare_rx("skew_fast");
        send_good(8'hC3, CPB + 1);
        idle(2 * CPB);
        compare_rx("skew_slow");

        // Random bytes with random idle gaps.
        for (int n = 0; n < 8; n++) begin
            send_good(8'($urandom_range(255)), CPB);
            idle(int'($urandom_range(3 * CPB)));
        end
        idle(2 * CPB);
        compare_rx("random");

        check("pulse_shape", 32'(overlap), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
